// File: rtl/bincnt_n.sv
// bincnt_n: N-bit synchronous presettable up/down counter with a cascadable terminal count.
// Define BINCNT_MODULO_EN to make it wrap at MODULO instead of 2**WIDTH.
module bincnt_n #(
  parameter int WIDTH  = 8,
  parameter int MODULO = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef BINCNT_MODULO_EN
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
`else
  localparam logic [WIDTH-1:0] TOP = '1;
`endif

  // An illegal modulus stops elaboration instead of producing an odd wrap.
  if (MODULO < 2 || MODULO > 2 ** WIDTH) begin : g_bad_modulo
    $error("bincnt_n: MODULO out of range 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] nxt;
  logic             ctl_poison;

  always_comb begin
    nxt = q_q;
    if (!load) begin
      nxt = d;
    end else if (en) begin
`ifdef BINCNT_MODULO_EN
      // Loaded values above the modulus wrap to 0 when counting up.
      if (up) nxt = (q_q >= TOP) ? '0 : q_q + ONE;
      else    nxt = (q_q == '0)  ? TOP : q_q - ONE;
`else
      nxt = up ? q_q + ONE : q_q - ONE;
`endif
    end
    // NOTE: x ^ x is x in simulation and 0 in hardware, so an unknown
    // control bit turns the whole next state unknown without adding logic.
    ctl_poison = ^{load, en, up};
    q_d        = nxt ^ {WIDTH{ctl_poison ^ ctl_poison}};
  end

  // NOTE: asynchronous clear sits in the sensitivity list; the state
  // update uses non-blocking assignment so every flop samples together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign tc = en & (q_q == (up ? TOP : '0));

endmodule

// File: tb/tb_bincnt_n.sv
// Directed self-checking bench for bincnt_n at WIDTH=4, plus a two-stage cascade.
`timescale 1ns/1ps
module tb_bincnt_n;

  logic       clk = 1'b0;
  logic       clr, load, en, up;
  logic [3:0] d, q;
  logic       tc;

  logic       clr_c, en0;
  logic [3:0] q0, q1;
  logic       tc0, tc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bincnt_n #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .d(d), .q(q), .tc(tc)
  );

  bincnt_n #(.WIDTH(4)) stage0 (
    .clk(clk), .clr(clr_c), .load(1'b1), .en(en0), .up(1'b1), .d(4'h0), .q(q0), .tc(tc0)
  );

  bincnt_n #(.WIDTH(4)) stage1 (
    .clk(clk), .clr(clr_c), .load(1'b1), .en(tc0), .up(1'b1), .d(4'h0), .q(q1), .tc(tc1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clr = 1'b0; load = 1'b1; en = 1'b0; up = 1'b1; d = 4'h0;
    clr_c = 1'b1; en0 = 1'b0;

    // Asynchronous clear between edges (clk falls at t=100, next rise at 105).
    #100 clr = 1'b1;
    en = 1'b1; up = 1'b1;
    #1;
    check("reset_q", {4'h0, q}, 8'h00);
    check("reset_tc_up", {7'h0, tc}, 8'h00);
    up = 1'b0;
    #1;
    check("reset_tc_down", {7'h0, tc}, 8'h01);

    // Load on the first edge after clear release.
    clr = 1'b0; load = 1'b0; d = 4'b0101; up = 1'b1;
    step();
    check("load_0101", {4'h0, q}, 8'h05);
    check("load_tc", {7'h0, tc}, 8'h00);

    // Up count with natural wrap.
    d = 4'b1110;
    step();
    load = 1'b1;
    check("load_1110", {4'h0, q}, 8'h0e);
    check("tc_at_1110", {7'h0, tc}, 8'h00);
    step();
    check("up_1111", {4'h0, q}, 8'h0f);
    check("tc_at_1111", {7'h0, tc}, 8'h01);
    step();
    check("up_wrap_0000", {4'h0, q}, 8'h00);
    check("tc_at_0000_up", {7'h0, tc}, 8'h00);
    step();
    check("up_0001", {4'h0, q}, 8'h01);
    en = 1'b0;
    step(3);
    check("hold_0001", {4'h0, q}, 8'h01);

    // Down count through zero.
    load = 1'b0; d = 4'b0010;
    step();
    load = 1'b1; en = 1'b1; up = 1'b0;
    check("load_0010", {4'h0, q}, 8'h02);
    step();
    check("down_0001", {4'h0, q}, 8'h01);
    step();
    check("down_0000", {4'h0, q}, 8'h00);
    check("tc_at_0000_down", {7'h0, tc}, 8'h01);
    step();
    check("down_wrap_1111", {4'h0, q}, 8'h0f);
    check("tc_at_1111_down", {7'h0, tc}, 8'h00);
    up = 1'b1;
    #1;
    check("tc_follows_up", {7'h0, tc}, 8'h01);

    // Load beats count; clear beats everything.
    load = 1'b0; en = 1'b1; up = 1'b1; d = 4'b1010;
    step();
    check("load_priority", {4'h0, q}, 8'h0a);
    load = 1'b1;
    #2 clr = 1'b1;
    #1;
    check("async_clr", {4'h0, q}, 8'h00);
    step();
    check("clr_held_edge", {4'h0, q}, 8'h00);
    #2 clr = 1'b0;
    step();
    check("count_on_release", {4'h0, q}, 8'h01);

    // Load above a decimal modulus, then count up.
    load = 1'b0; d = 4'b1100;
    step();
    load = 1'b1; en = 1'b1; up = 1'b1;
    step();
`ifdef BINCNT_MODULO_EN
    check("mod_overrange_wrap", {4'h0, q}, 8'h00);

    // Modulo-10 cycle with tc only at 9.
    for (int i = 1; i <= 10; i++) begin
      step();
      check("mod_up_q", {4'h0, q}, 8'(i % 10));
      check("mod_up_tc", {7'h0, tc}, (i % 10 == 9) ? 8'h01 : 8'h00);
    end
    up = 1'b0;
    step();
    check("mod_down_wrap", {4'h0, q}, 8'h09);
`else
    check("bin_1100_up", {4'h0, q}, 8'h0d);
`endif

    // Two-stage cascade from reset.
    #2 clr_c = 1'b0; en0 = 1'b1;
    step(16);
    check("cas16_q0", {4'h0, q0}, 8'h00);
    check("cas16_q1", {4'h0, q1}, 8'h01);
    step(239);
    check("cas255_q0", {4'h0, q0}, 8'h0f);
    check("cas255_q1", {4'h0, q1}, 8'h0f);
    check("cas255_tc1", {7'h0, tc1}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bincnt_n.md
# bincnt_n

Parametrised synchronous presettable binary up/down counter; the single-clock, N-bit successor to the 4-bit presettable ripple counter in the TTL model collection. It adds:
- count enable
- direction control
- a cascadable terminal-count output
- an optional programmable modulus

It is the general counter/divider primitive for board-level models that need wider or non-power-of-two counts.

## Interface
- WIDTH, 8, counter width in bits (≥ 2)
- MODULO, 2**WIDTH, count modulus; used only when BINCNT_MODULO_EN is defined; legal range 2..2**WIDTH
- clk  input  1  clock; all state changes on rising edge except reset
- clr  input  1  reset, asynchronous, active-high; forces q to 0 immediately
- load  input  1  synchronous parallel load, active-low
- en  input  1  count enable, active-high; also gates tc (cascade input)
- up  input  1  direction: 1 = count up, 0 = count down
- d  input  WIDTH  parallel load data
- q  output  WIDTH  counter state, registered
- tc  output  1  terminal count, combinational from q, en, up

## Operation
- Priority, highest first: clr, load, en, hold.
- clr=1: q=0 asynchronously, independent of clk. q stays 0 while clr is held.
- load=0 on rising clk (clr=0): q<=d. This ignores en and up.
- load=1, en=1: q<=q+1 if up=1, q<=q-1 if up=0, with wrap (see below).
- load=1, en=0: q holds.
- Arithmetic is unsigned, WIDTH bits. Without the macro, wrap is natural: up from 2**WIDTH-1 gives 0, down from 0 gives 2**WIDTH-1.
- Terminal value T:
  - up=1: T = top, where top = 2**WIDTH-1 without the macro and MODULO-1 with it.
  - up=0: T = 0.
- tc = en & (q == T). This is for cascading: tc of stage k drives en of stage k+1, all stages on a common clk.
- Reset values: q=0. tc = en & ~up (top ≠ 0 because WIDTH ≥ 2 and MODULO ≥ 2).
- Direction change: takes effect on the next edge. No pipeline state, no lost count.
- X or Z on load, en or up at a rising edge drives q to all-x (simulation model). X on d during load loads x.

## Timing
- Counting and load latency: 1 clk. q updates on the rising edge where the condition is sampled.
- clr assertion: q=0 within the model's propagation delay (0 ns, RTL), with no clk needed.
- clr release: the first edge with clr=0 acts normally. A load or count on the same edge as clr deassertion is honoured.
- tc: combinational. It is valid after q settles and follows en/up changes without a clock.
- clr asserted mid-count or mid-load: the pending edge is discarded and q=0.

## Configuration
- BINCNT_MODULO_EN defined: the counter is modulo-MODULO.
  - Up from any q ≥ MODULO-1 gives 0. Out-of-range values can come from load.
  - Down from 0 gives MODULO-1.
  - Down from q ≥ MODULO decrements normally until back in range.
  - top = MODULO-1.
- BINCNT_MODULO_EN undefined: MODULO is ignored. Pure binary wrap at 2**WIDTH, top = 2**WIDTH-1, no compare logic.

## Test plan
All scenarios use WIDTH=4.
- Reset, then load: clr=1 at t=100 gives q=0000 with no clock edge. Then clr=0, load=0, d=0101, one edge gives q=0101. tc=0 with en=1, up=1.
- Up count with wrap, no macro: load 1110, then en=1, up=1.
  - Edges give q=1111 (tc=1), then 0000 (tc=0), then 0001.
  - en=0 for 3 edges: q stays 0001.
- Down count: load 0010, en=1, up=0.
  - Edges give q=0001, 0000 (tc=1), then 1111.
  - Toggle up to 1 with q=1111: tc goes 0 to 1 without an edge.
- Priority: load=0, en=1, up=1, d=1010 on an edge gives q=1010, not an increment. Assert clr asynchronously between edges: q=0000 at once.
- BINCNT_MODULO_EN with MODULO=10:
  - Up from 0 for 10 edges: q cycles 0..9 then 0. tc=1 only at q=1001.
  - Down from 0 gives 1001.
  - Load 1100 and count up: next edge gives 0000.
- Cascade: two instances, stage0.tc drives stage1.en, both up=1, en0=1, no macro. After 16 edges stage1.q=0001 and stage0.q=0000. After 255 edges from reset both are 1111 and stage1.tc=1.
